// File: rtl/mips_pkg.sv
// Shared definitions for the fetch unit and the control decoder.
// Holds opcode/funct constants, the fetch FSM state type and the default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        StBoot,
        StReq,
        StHold
    } fetch_state_e;

    // Sign-extended word offset of a 16-bit branch immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: jr over j/jal over taken branch over sequential.
module next_pc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic [31:0] rs_value,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    output logic [31:0] npc
);

    logic unused_bits;
    assign unused_bits = ^{rs_value[1:0], instr[31:26]};

    always_comb begin
        npc = pc_plus4;
        if (jump_reg) begin
            npc = {rs_value[31:2], 2'b00};
        end else if (jump) begin
            npc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch_taken) begin
            npc = pc_plus4 + branch_offset(instr[15:0]);
        end
    end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, fetches over req/ack and hands words to decode
// over valid/ready, one instruction in flight.
module ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] rs_value
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, pc_out_q, pc_plus4_q;
    logic [31:0]  npc;
    logic         capture;

    // Ack only counts once REQ is the registered state.
    assign capture = (state_q == StReq) && imem_ack;

    next_pc u_next_pc (
        .pc_plus4     (pc_plus4_q),
        .instr        (instr_q),
        .rs_value     (rs_value),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .npc          (npc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            StBoot: state_d = StReq;
            StReq: begin
                if (imem_ack) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (instr_ready) begin
                    state_d = StReq;
                    pc_d    = npc;
                end
            end
            default: state_d = StBoot;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            pc_out_q   <= '0;
            pc_plus4_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                instr_q    <= imem_rdata;
                pc_out_q   <= pc_q;
                pc_plus4_q <= pc_q + 32'd4;
            end
        end
    end

    assign imem_req    = (state_q == StReq);
    assign imem_addr   = imem_req ? pc_q : '0;
    assign instr_valid = (state_q == StHold);
    assign instr       = instr_q;
    assign opcode      = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_plus4_q;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch; inputs change and outputs are sampled on negedge.
module tb_ifetch;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        branch_taken;
    logic        jump;
    logic        jump_reg;
    logic [31:0] rs_value;

    int checks;
    int errors;

    ifetch dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr        (instr),
        .opcode       (opcode),
        .funct        (funct),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .rs_value     (rs_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", instr_valid); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
        checks++; if ({opcode, funct} !== 12'h0) begin errors++; $display("FAIL rst_fields got %h exp 0", {opcode, funct}); end
        checks++; if (pc_out !== 32'h0 || pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc got %h/%h exp 0/0", pc_out, pc_plus4); end
        rst_n = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL boot_req got %b exp 0", imem_req); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h exp 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_zero_wait();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL zw_hold got valid %b req %b exp 1/0", instr_valid, imem_req); end
        checks++; if (instr !== 32'h0000_0020) begin errors++; $display("FAIL zw_instr got %h exp 00000020", instr); end
        checks++; if (opcode !== 6'h00 || funct !== 6'h20) begin errors++; $display("FAIL zw_fields got %h/%h exp 00/20", opcode, funct); end
        checks++; if (pc_out !== 32'h0 || pc_plus4 !== 32'h4) begin errors++; $display("FAIL zw_pc got %h/%h exp 0/4", pc_out, pc_plus4); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL zw_addr4 got %b/%h exp 1/00000004", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h2108_0001;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (opcode !== 6'h08 || pc_out !== 32'h4) begin errors++; $display("FAIL zw_second got %h/%h exp 08/00000004", opcode, pc_out); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL zw_addr8 got %b/%h exp 1/00000008", imem_req, imem_addr); end
    endtask

    // Leaves the beq word (pc 0x8, imm 0xFFFE) held with instr_ready low.
    task automatic test_wait_states();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8 || instr_valid !== 1'b0) begin errors++; $display("FAIL ws_wait%0d got %b/%h/%b exp 1/00000008/0", i, imem_req, imem_addr, instr_valid); end
            @(negedge clk);
        end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin errors++; $display("FAIL ws_last got %b/%h exp 1/00000008", imem_req, imem_addr); end
        imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
        @(negedge clk);
        checks++; if (instr_valid !== 1'b1 || instr !== 32'h1000_FFFE) begin errors++; $display("FAIL ws_valid got %b/%h exp 1/1000fffe", instr_valid, instr); end
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr !== 32'h1000_FFFE || instr_valid !== 1'b1) begin errors++; $display("FAIL ws_hold_ack got %h/%b exp 1000fffe/1", instr, instr_valid); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 32'h1000_FFFE || pc_out !== 32'h8) begin
                errors++; $display("FAIL bp_cycle%0d got valid %b req %b instr %h pc %h exp 1/0/1000fffe/00000008", i, instr_valid, imem_req, instr, pc_out);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        branch_taken = 1'b1; instr_ready = 1'b1;
        @(negedge clk);
        branch_taken = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL beq_target got %b/%h exp 1/00000004", imem_req, imem_addr); end
    endtask

    task automatic test_jump();
        jump_reg = 1'b1; rs_value = 32'h0000_5000;
        imem_ack = 1'b1; imem_rdata = 32'h0800_0100;
        @(negedge clk);
        imem_ack = 1'b0; jump_reg = 1'b0; jump = 1'b1;
        checks++; if (pc_out !== 32'h4 || opcode !== 6'h02) begin errors++; $display("FAIL j_hold got %h/%h exp 00000004/02", pc_out, opcode); end
        @(negedge clk);
        jump = 1'b0;
        checks++; if (imem_addr !== 32'h400) begin errors++; $display("FAIL j_target got %h exp 00000400", imem_addr); end
    endtask

    task automatic test_jr();
        imem_ack = 1'b1; imem_rdata = 32'h0080_0008;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (funct !== 6'h08 || pc_out !== 32'h400) begin errors++; $display("FAIL jr_hold got %h/%h exp 08/00000400", funct, pc_out); end
        jump_reg = 1'b1; rs_value = 32'h0000_1003;
        @(negedge clk);
        jump_reg = 1'b0;
        checks++; if (imem_addr !== 32'h1000) begin errors++; $display("FAIL jr_target got %h exp 00001000", imem_addr); end
    endtask

    task automatic test_priority();
        imem_ack = 1'b1; imem_rdata = 32'h1000_0010;
        @(negedge clk);
        imem_ack = 1'b0;
        jump_reg = 1'b1; branch_taken = 1'b1; rs_value = 32'h0000_2000;
        @(negedge clk);
        jump_reg = 1'b0; branch_taken = 1'b0;
        checks++; if (imem_addr !== 32'h2000) begin errors++; $display("FAIL prio_target got %h exp 00002000", imem_addr); end
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'h0000_0020;
        @(negedge clk);
        imem_ack = 1'b0;
        jump_reg = 1'b1; rs_value = 32'hFFFF_FFFF;
        @(negedge clk);
        jump_reg = 1'b0;
        checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (pc_out !== 32'hFFFF_FFFC || pc_plus4 !== 32'h0) begin errors++; $display("FAIL wrap_pc got %h/%h exp fffffffc/00000000", pc_out, pc_plus4); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_next got %b/%h exp 1/00000000", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_ctl got %b/%h/%b exp 0/0/0", imem_req, imem_addr, instr_valid); end
        checks++; if (instr !== 32'h0 || pc_out !== 32'h0) begin errors++; $display("FAIL mid_rst_data got %h/%h exp 0/0", instr, pc_out); end
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin errors++; $display("FAIL mid_restart got %b/%h/%b exp 1/0/0", imem_req, imem_addr, instr_valid); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 32'h0) begin errors++; $display("FAIL mid_late_ack got %b/%b/%h exp 1/0/0", imem_req, instr_valid, instr); end
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        @(negedge clk);
        imem_ack = 1'b0;
        checks++; if (instr !== 32'h1234_5678 || pc_out !== 32'h0) begin errors++; $display("FAIL mid_refetch got %h/%h exp 12345678/0", instr, pc_out); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
        branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0; rs_value = '0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_backpressure();
        test_branch();
        test_jump();
        test_jr();
        test_priority();
        test_wrap();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit sitting upstream of the control decoder: it owns the PC, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents each word (with its opcode and funct fields) to decode over a valid/ready handshake. On consumption it takes the decoder's branch/jump decision and computes the next PC (sequential, branch, `j`/`jal`, `jr`). There are no delay slots; the core runs one instruction in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  32  fetch address (word-aligned, [1:0]=00)
- `imem_ack`  in  1  single-cycle pulse: `imem_rdata` valid this cycle
- `imem_rdata`  in  32  fetched word
- `instr_valid`  out  1  instruction word available to decode
- `instr_ready`  in  1  decode accepts the word this cycle
- `instr`  out  32  held instruction word
- `opcode`  out  6  `instr[31:26]`
- `funct`  out  6  `instr[5:0]`
- `pc_out`  out  32  address of `instr`
- `pc_plus4`  out  32  `pc_out + 4` (link value for `jal`)
- `branch_taken`  in  1  conditional branch resolved taken (`beq`/`bne`)
- `jump`  in  1  `j`/`jal` decoded
- `jump_reg`  in  1  `jr` decoded
- `rs_value`  in  32  register rs contents (`jr` target)

## Operation
- FSM states: BOOT, REQ, HOLD.
- BOOT: reset state. All outputs 0. Goes to REQ on the first `clk` edge with `rst_n` high. PC = `RESET_PC`.
- REQ: `imem_req`=1 and `imem_addr`=PC. When `imem_ack` is sampled high, capture `imem_rdata` into `instr` and go to HOLD. Otherwise stay in REQ, with the address held stable.
- HOLD: `instr_valid`=1. `instr`, `pc_out` and `pc_plus4` are held stable. When `instr_ready`=1, load the next PC and go to REQ. Otherwise stay in HOLD.
- Next PC is selected on the accept cycle (`instr_valid & instr_ready`), priority highest first:
  - `jump_reg`: `{rs_value[31:2],2'b00}`. Misaligned low bits are dropped.
  - `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - `branch_taken`: `pc_plus4 + ({{14{instr[15]}},instr[15:0],2'b00})`. This is 32-bit modular; wrap-around is ignored.
  - else: `pc_plus4`. `0xFFFF_FFFC` wraps to `0x0000_0000`.
- Redirect inputs are ignored outside the accept cycle.
- `imem_ack` is ignored outside REQ. An ack arriving in the same cycle the FSM enters REQ is not accepted; the first usable ack is the one sampled while REQ is registered.
- Reset asserted in any state forces BOOT asynchronously. Any pending ack is discarded and `instr_valid` drops immediately.
- Reset values: `imem_req`=0, `imem_addr`=0, `instr_valid`=0, `instr`=0, `opcode`=0, `funct`=0, `pc_out`=0, `pc_plus4`=0. The internal PC resets to `RESET_PC`.

## Timing
- First `imem_req` appears the cycle after the first post-reset edge (BOOT→REQ).
- With a zero-wait memory (ack in the first REQ cycle), the minimum throughput is 2 cycles per instruction: REQ, then HOLD with ready.
- With N wait cycles, REQ lasts N+1 cycles.
- `instr_valid` rises the cycle after the ack edge.
- `imem_req`/`imem_addr` and `instr_valid`/`instr`/`pc_out` are decoded from registered state only. There is no combinational path from any input to any output.
- Decode may drive `branch_taken`/`jump`/`jump_reg`/`rs_value` combinationally from `instr`. The next PC is registered at the accept edge.

## Structure
- Shared package `mips_pkg`:
  - opcode constants `OP_RTYPE`, `OP_J`, `OP_JAL`, `OP_BEQ`, `OP_BNE`, and `FN_JR`, also used by the control decoder;
  - the fetch state enum (BOOT/REQ/HOLD);
  - the default `RESET_PC`.
- One sub-module, `next_pc`: purely combinational. Inputs are `pc_plus4`, `instr`, `rs_value` and the three redirect flags; output is the 32-bit next PC. It is unit-tested separately.

## Test plan
- Reset, then zero-wait memory with `instr_ready` tied 1:
  - `imem_addr` sequence 0x0, 0x4, 0x8, with `imem_req` 0 during reset and in BOOT;
  - instruction 0x0000_0020 (add) gives `opcode`=0, `funct`=0x20.
- 3-wait-cycle memory: `imem_req`/`imem_addr` are held for 4 cycles; `instr_valid` rises one cycle after the ack; an ack pulsed while in HOLD is ignored.
- Backpressure: `instr_ready`=0 for 5 cycles; `instr`/`pc_out` are stable and no new `imem_req` is issued.
- Redirects:
  - `beq` at pc 0x8, imm 0xFFFE, `branch_taken`=1: next fetch 0x4;
  - `j` with index 0x100 at pc 0x4: next fetch 0x400;
  - `jr` with `rs_value`=0x1003: next fetch 0x1000;
  - `jump_reg`+`branch_taken` both high: `jr` target wins.
- Wrap: PC 0xFFFF_FFFC sequential leads to fetch 0x0.
- Reset asserted mid-wait in REQ: outputs are 0 immediately; after release, fetch restarts at `RESET_PC` and the late ack is discarded.
